// File: rtl/wr_sel_ctrl.sv
// wr_sel_ctrl: multicycle control FSM for the register-file write-back path.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) for the supported subset.
// It drives the Mux_WR selector, the register-file write enable, and the
// PC, IR and memory strobes. Outputs are decoded combinationally from the
// state, the opcode/funct latched in DECODE, and the wait counter.
module wr_sel_ctrl #(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [1:0] wr_sel,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic [1:0] alu_op,
    output logic       excp,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_EXCP   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        K_RALU = 4'd0,
        K_JR   = 4'd1,
        K_ADDI = 4'd2,
        K_LW   = 4'd3,
        K_SW   = 4'd4,
        K_BEQ  = 4'd5,
        K_J    = 4'd6,
        K_JAL  = 4'd7,
        K_BAD  = 4'd8
    } kind_t;

    // Last value of the wait counter. An access lasts MEM_WAIT+1 cycles.
    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

    // Mux_WR select encodings
    localparam logic [1:0] WR_RT  = 2'b00;
    localparam logic [1:0] WR_RD  = 2'b01;
    localparam logic [1:0] WR_R31 = 2'b10;

    // PC source encodings
    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;
    localparam logic [1:0] PC_RS  = 2'b11;

    // ALU operation encodings
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    state_t     state_r;
    logic [2:0] cnt_r;
    logic [5:0] op_r;
    logic [5:0] funct_r;
    kind_t      kind_s;
    kind_t      dec_kind_s;
    logic       cnt_last_s;

    // Map an opcode/funct pair onto an instruction class. Anything outside
    // the supported subset is reported as K_BAD.
    function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
        kind_t k;
        k = K_BAD;
        case (op)
            6'h00: begin
                case (fn)
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: k = K_RALU;
                    6'h08:                             k = K_JR;
                    default:                           k = K_BAD;
                endcase
            end
            6'h08:   k = K_ADDI;
            6'h23:   k = K_LW;
            6'h2B:   k = K_SW;
            6'h04:   k = K_BEQ;
            6'h02:   k = K_J;
            6'h03:   k = K_JAL;
            default: k = K_BAD;
        endcase
        return k;
    endfunction

    // The latched fields drive EXEC/MEM/WB. The raw fields are decoded only in DECODE.
    assign kind_s     = classify(op_r, funct_r);
    assign dec_kind_s = classify(opcode, funct);
    assign cnt_last_s = (cnt_r == WAIT_LAST);
    assign state_o    = state_r;

    // State sequencing, wait counter and opcode/funct capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_RST;
            cnt_r   <= 3'd0;
            op_r    <= 6'd0;
            funct_r <= 6'd0;
        end else begin
            case (state_r)
                S_RST: begin
                    cnt_r   <= 3'd0;
                    state_r <= S_FETCH;
                end
                S_FETCH: begin
                    if (cnt_last_s) begin
                        cnt_r   <= 3'd0;
                        state_r <= S_DECODE;
                    end else begin
                        cnt_r <= cnt_r + 3'd1;
                    end
                end
                S_DECODE: begin
                    op_r    <= opcode;
                    funct_r <= funct;
                    if (dec_kind_s == K_BAD) begin
                        state_r <= S_EXCP;
                    end else begin
                        state_r <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (kind_s)
                        K_RALU, K_ADDI: state_r <= S_WB;
                        K_LW, K_SW:     state_r <= S_MEM;
                        default:        state_r <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (cnt_last_s) begin
                        cnt_r <= 3'd0;
                        if (kind_s == K_LW) begin
                            state_r <= S_WB;
                        end else begin
                            state_r <= S_FETCH;
                        end
                    end else begin
                        cnt_r <= cnt_r + 3'd1;
                    end
                end
                S_WB:    state_r <= S_FETCH;
                S_EXCP:  state_r <= S_FETCH;
                default: begin
                    cnt_r   <= 3'd0;
                    state_r <= S_RST;
                end
            endcase
        end
    end

    // Output decode from the state, the latched class and the wait counter
    always_comb begin
        wr_sel     = WR_RT;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_INC;
        alu_op     = ALU_ADD;
        excp       = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_read = 1'b1;
                alu_op   = ALU_ADD;
                if (cnt_last_s) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PC_INC;
                end else begin
                    ir_write = 1'b0;
                    pc_write = 1'b0;
                end
            end
            S_DECODE: begin
                // The ALU computes the branch target in DECODE.
                alu_op = ALU_ADD;
            end
            S_EXEC: begin
                case (kind_s)
                    K_RALU: alu_op = ALU_FUNCT;
                    K_ADDI, K_LW, K_SW: alu_op = ALU_ADD;
                    K_BEQ: begin
                        alu_op   = ALU_SUB;
                        pc_src   = PC_BR;
                        pc_write = zero;
                    end
                    K_J: begin
                        pc_write = 1'b1;
                        pc_src   = PC_JMP;
                    end
                    K_JR: begin
                        pc_write = 1'b1;
                        pc_src   = PC_RS;
                    end
                    K_JAL: begin
                        pc_write   = 1'b1;
                        pc_src     = PC_JMP;
                        reg_write  = 1'b1;
                        wr_sel     = WR_R31;
                        mem_to_reg = 1'b0;
                    end
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_MEM: begin
                if (kind_s == K_LW) begin
                    mem_read = 1'b1;
                end else if (kind_s == K_SW) begin
                    mem_write = 1'b1;
                end else begin
                    mem_read  = 1'b0;
                    mem_write = 1'b0;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                case (kind_s)
                    K_RALU: begin
                        wr_sel     = WR_RD;
                        mem_to_reg = 1'b0;
                    end
                    K_LW: begin
                        wr_sel     = WR_RT;
                        mem_to_reg = 1'b1;
                    end
                    default: begin
                        wr_sel     = WR_RT;
                        mem_to_reg = 1'b0;
                    end
                endcase
            end
            S_EXCP: begin
                excp = 1'b1;
            end
            default: begin
                excp = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_wr_sel_ctrl.sv
// tb_wr_sel_ctrl: self-checking bench for wr_sel_ctrl.
// A reference model turns each instruction into the list of per-cycle
// output vectors the controller must produce. The bench then compares
// the DUT against that list on every falling edge.
module tb_wr_sel_ctrl;

    localparam int W = 1;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic [1:0] wr_sel;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       excp;
    logic [2:0] state_o;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [15:0] exp_q[$];
    logic [15:0] obs_v;

    wr_sel_ctrl #(.MEM_WAIT(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .funct     (funct),
        .zero      (zero),
        .wr_sel    (wr_sel),
        .reg_write (reg_write),
        .mem_to_reg(mem_to_reg),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .alu_op    (alu_op),
        .excp      (excp),
        .state_o   (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs_v = {state_o, wr_sel, reg_write, mem_to_reg, mem_read, mem_write,
                    ir_write, pc_write, pc_src, alu_op, excp};

    // Pack one cycle of expected outputs into the same layout as obs_v.
    function automatic logic [15:0] mk(input logic [2:0] st, input logic [1:0] ws,
                                       input logic rw, input logic m2r, input logic mr,
                                       input logic mw, input logic irw, input logic pcw,
                                       input logic [1:0] ps, input logic [1:0] ao,
                                       input logic ex);
        return {st, ws, rw, m2r, mr, mw, irw, pcw, ps, ao, ex};
    endfunction

    // Instruction class named from the opcode/funct tables.
    function automatic string kind_of(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) begin
            if (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A)
                return "ralu";
            else if (fn == 6'h08)
                return "jr";
            else
                return "bad";
        end
        case (op)
            6'h08:   return "addi";
            6'h23:   return "lw";
            6'h2B:   return "sw";
            6'h04:   return "beq";
            6'h02:   return "j";
            6'h03:   return "jal";
            default: return "bad";
        endcase
    endfunction

    // Build the full expected cycle list for one instruction.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z);
        string k;
        k = kind_of(op, fn);
        exp_q.delete();
        for (int c = 0; c <= W; c++) begin
            logic last;
            last = (c == W);
            exp_q.push_back(mk(3'd1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, last, last, 2'b00, 2'b00, 1'b0));
        end
        exp_q.push_back(mk(3'd2, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
        if (k == "bad") begin
            exp_q.push_back(mk(3'd6, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1));
            return;
        end
        case (k)
            "ralu": exp_q.push_back(mk(3'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0));
            "beq":  exp_q.push_back(mk(3'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, z,    2'b01, 2'b01, 1'b0));
            "j":    exp_q.push_back(mk(3'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0));
            "jr":   exp_q.push_back(mk(3'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 2'b00, 1'b0));
            "jal":  exp_q.push_back(mk(3'd3, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0));
            default: exp_q.push_back(mk(3'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
        endcase
        if (k == "lw" || k == "sw") begin
            for (int c = 0; c <= W; c++)
                exp_q.push_back(mk(3'd4, 2'b00, 1'b0, 1'b0, k == "lw", k == "sw",
                                   1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
        end
        if (k == "ralu")
            exp_q.push_back(mk(3'd5, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
        else if (k == "addi")
            exp_q.push_back(mk(3'd5, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
        else if (k == "lw")
            exp_q.push_back(mk(3'd5, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Invariants that must hold on every cycle.
    task automatic check_inv();
        check("inv_ws11", {15'd0, (reg_write === 1'b1) && (wr_sel === 2'b11)}, 16'd0);
        check("inv_mrmw", {15'd0, (mem_read === 1'b1) && (mem_write === 1'b1)}, 16'd0);
    endtask

    // Run one instruction against the model. The raw fields are scrambled
    // once they have been latched. Optionally, reset is asserted in the first MEM cycle.
    task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input bit rst_mid);
        opcode = op;
        funct  = fn;
        zero   = z;
        build(op, fn, z);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            check($sformatf("%s_c%0d", tag, i), obs_v, exp_q[i]);
            check_inv();
            if (i > 0 && exp_q[i-1][15:13] == 3'd2) begin
                opcode = 6'($urandom);
                funct  = 6'($urandom);
            end
            if (rst_mid && exp_q[i][15:13] == 3'd4) begin
                reset = 1'b1;
                for (int r = 0; r < 3; r++) begin
                    @(negedge clk);
                    check($sformatf("%s_rst%0d", tag, r), obs_v, 16'd0);
                end
                reset = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        logic [5:0] tbl_op[14];
        logic [5:0] tbl_fn[14];
        tbl_op = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08,
                   6'h23, 6'h2B, 6'h04, 6'h02, 6'h03, 6'h3F, 6'h00};
        tbl_fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08, 6'h11,
                   6'h05, 6'h3A, 6'h00, 6'h01, 6'h3C, 6'h00, 6'h3F};

        reset  = 1'b1;
        opcode = 6'd0;
        funct  = 6'd0;
        zero   = 1'b0;
        @(negedge clk);
        check("reset_hold0", obs_v, 16'd0);
        @(negedge clk);
        check("reset_hold1", obs_v, 16'd0);
        reset = 1'b0;

        run_instr("add",    6'h00, 6'h20, 1'b0, 1'b0);
        run_instr("lw",     6'h23, 6'h00, 1'b0, 1'b0);
        run_instr("jal",    6'h03, 6'h00, 1'b0, 1'b0);
        run_instr("beq_z0", 6'h04, 6'h00, 1'b0, 1'b0);
        run_instr("beq_z1", 6'h04, 6'h00, 1'b1, 1'b0);
        run_instr("bad_op", 6'h3F, 6'h00, 1'b0, 1'b0);
        run_instr("bad_fn", 6'h00, 6'h3F, 1'b0, 1'b0);
        run_instr("sw",     6'h2B, 6'h00, 1'b0, 1'b0);
        run_instr("addi",   6'h08, 6'h00, 1'b0, 1'b0);
        run_instr("jr",     6'h00, 6'h08, 1'b0, 1'b0);
        run_instr("j",      6'h02, 6'h00, 1'b0, 1'b0);
        run_instr("lw_rst", 6'h23, 6'h00, 1'b0, 1'b1);
        run_instr("after_rst", 6'h00, 6'h22, 1'b0, 1'b0);
        run_instr("sw_rst", 6'h2B, 6'h00, 1'b1, 1'b1);
        run_instr("after_rst2", 6'h23, 6'h00, 1'b0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            logic [5:0] op;
            logic [5:0] fn;
            int         idx;
            idx = int'($urandom_range(0, 13));
            op  = tbl_op[idx];
            fn  = tbl_fn[idx];
            if ($urandom_range(0, 4) == 0) begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end
            run_instr($sformatf("rnd%0d", n), op, fn, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
